// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: four push buttons select OFF / MIRROR / RUN / BLINK and pause.
// Define LED_KEY_DEBOUNCE_EN to insert a per-key DEB_CNT-cycle debounce filter after the synchroniser.
module led_pattern_ctrl #(
  parameter int N_LED    = 4,
  parameter int STEP_CNT = 10_000_000,
  parameter int DEB_CNT  = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [3:0]       key,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode,
  output logic             paused
);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_MIRROR = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  localparam int STEP_W = $clog2(N_LED);
  localparam int TMR_W  = $clog2(STEP_CNT);
  localparam int DEB_W  = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;

  if (N_LED < 2 || N_LED > 16 || (N_LED % 2) != 0 || STEP_CNT < 2 || DEB_CNT < 2 || DEB_W < 1)
  begin : g_param_err
    $error("led_pattern_ctrl: illegal parameter value");
  end

  // Key synchroniser; sync_vld marks when sync_q2 holds a real post-reset sample.
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;
  logic [1:0] sync_vld;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1  <= '1;
      sync_q2  <= '1;
      sync_vld <= '0;
    end else begin
      sync_q1  <= key;
      sync_q2  <= sync_q1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  logic [3:0] key_lvl;

`ifdef LED_KEY_DEBOUNCE_EN
  logic [DEB_W-1:0] deb_cnt [4];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_lvl <= '1;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q2[i] == key_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CNT - 1)) begin
          key_lvl[i] <= sync_q2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign key_lvl = sync_q2;
`endif

  // A key only arms once it has been seen released after reset, so a key held
  // through reset release cannot produce a press.
  logic [3:0] lvl_prev;
  logic [3:0] armed;
  logic [3:0] press;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lvl_prev <= '1;
      armed    <= '0;
    end else begin
      lvl_prev <= key_lvl;
      armed    <= armed | ({4{sync_vld[1]}} & sync_q2);
    end
  end

  assign press = armed & lvl_prev & ~key_lvl;

  logic [3:0] win;

  always_comb begin
    win = '0;
    if (press[0])      win = 4'b0001;
    else if (press[1]) win = 4'b0010;
    else if (press[2]) win = 4'b0100;
    else if (press[3]) win = 4'b1000;
  end

  logic [1:0] mode_nxt;
  logic       mode_chg;

  always_comb begin
    mode_nxt = mode;
    if (win[0])      mode_nxt = (mode == MODE_MIRROR) ? MODE_OFF : MODE_MIRROR;
    else if (win[1]) mode_nxt = (mode == MODE_RUN)    ? MODE_OFF : MODE_RUN;
    else if (win[2]) mode_nxt = (mode == MODE_BLINK)  ? MODE_OFF : MODE_BLINK;
    mode_chg = (mode_nxt != mode);
  end

  logic [TMR_W-1:0]  tmr;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_last;

  always_comb begin
    step_last = '0;
    case (mode)
      MODE_RUN:    step_last = STEP_W'(N_LED - 1);
      MODE_MIRROR: step_last = STEP_W'(N_LED / 2 - 1);
      MODE_BLINK:  step_last = STEP_W'(1);
      default:     step_last = '0;
    endcase
  end

  // A pause toggle cycle does not advance the timer; OFF keeps timer/step at 0
  // because every entry into OFF is a mode change, which clears them.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode   <= MODE_OFF;
      paused <= 1'b0;
      tmr    <= '0;
      step   <= '0;
    end else if (mode_chg) begin
      mode   <= mode_nxt;
      paused <= 1'b0;
      tmr    <= '0;
      step   <= '0;
    end else if (win[3]) begin
      if (mode != MODE_OFF) paused <= ~paused;
    end else if (mode != MODE_OFF && !paused) begin
      if (tmr == TMR_W'(STEP_CNT - 1)) begin
        tmr  <= '0;
        step <= (step == step_last) ? '0 : step + 1'b1;
      end else begin
        tmr <= tmr + 1'b1;
      end
    end
  end

  logic [N_LED-1:0] led_nxt;

  always_comb begin
    led_nxt = '0;
    case (mode)
      MODE_RUN: begin
        for (int i = 0; i < N_LED; i++) led_nxt[i] = (STEP_W'(i) == step);
      end
      MODE_MIRROR: begin
        for (int i = 0; i < N_LED; i++)
          led_nxt[i] = (STEP_W'(i) == step) || (STEP_W'(N_LED - 1 - i) == step);
      end
      MODE_BLINK: led_nxt = {N_LED{~step[0]}};
      default:    led_nxt = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) led <= '0;
    else            led <= led_nxt;
  end

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 The module SHALL have parameter N_LED, default 4, number of LED outputs; legal range 2..16, even values only.
REQ-002 The module SHALL have parameter STEP_CNT, default 10_000_000, clock cycles per pattern step (0.2 s at 50 MHz); legal range >= 2.
REQ-003 The module SHALL have parameter DEB_CNT, default 1_000_000, consecutive stable cycles a key needs to be accepted (20 ms at 50 MHz); legal range >= 2.
REQ-004 The module SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-005 The module SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port key  input  4  raw asynchronous push buttons, active-low (0 = pressed).
REQ-007 The module SHALL have port led  output  N_LED  registered LED drive, 1 = on.
REQ-008 The module SHALL have port mode  output  2  registered current mode: 00 OFF, 01 MIRROR, 10 RUN, 11 BLINK.
REQ-009 The module SHALL have port paused  output  1  registered, 1 = step advance frozen.

Function
REQ-010 Each key bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-011 A press event SHALL be a single-cycle pulse on the 1->0 transition of the conditioned key level, per key.
REQ-012 Mode SHALL be latched by press events, not held with the key: key[0] -> MIRROR, key[1] -> RUN, key[2] -> BLINK.
REQ-013 key[3] press SHALL toggle paused while mode != OFF, and SHALL be ignored in OFF.
REQ-014 Simultaneous press events SHALL resolve by priority key[0] > key[1] > key[2] > key[3]; only the winner acts.
REQ-015 Pressing the key of the current mode SHALL return the mode to OFF and clear paused.
REQ-016 Any mode change SHALL clear paused, the step timer and the step index, same cycle as the mode update.
REQ-017 The step timer SHALL count 0..STEP_CNT-1 and wrap; on wrap with paused=0 the step index SHALL advance by 1.
REQ-018 With paused=1 the timer and step index SHALL hold their values; on resume counting SHALL continue from the held values.
REQ-019 RUN: led = one-hot bit[step]; step wraps N_LED-1 -> 0.
REQ-020 MIRROR: led = bit[step] | bit[N_LED-1-step]; step wraps N_LED/2-1 -> 0 (N_LED=4: 1001, 0110, 1001, ...).
REQ-021 BLINK: led = all ones for even step, all zeros for odd; step wraps 1 -> 0.
REQ-022 OFF: led = all zeros; timer and step held at 0.
REQ-023 mode SHALL update one cycle after the press pulse; led SHALL show step-0 pattern of the new mode the following cycle.
REQ-024 Step index width SHALL be the minimum to hold N_LED-1; timer width the minimum to hold STEP_CNT-1; no overflow beyond the defined wrap points.

Reset
REQ-025 While sys_rst_n=0: led=0, mode=00, paused=0, timer=0, step=0, synchroniser and debounce state = all keys released (1).
REQ-026 Reset assertion mid-pattern SHALL take effect immediately, without waiting for sys_clk; no press event SHALL be generated by keys held low through reset release until they are released and pressed again.

Configuration
REQ-027 With macro LED_KEY_DEBOUNCE_EN defined, each synchronised key SHALL update its conditioned level only after DEB_CNT consecutive cycles of a differing value; any bounce restarts that key's counter.
REQ-028 Without LED_KEY_DEBOUNCE_EN, the conditioned level SHALL equal the synchroniser output, DEB_CNT SHALL be unused, and no debounce counters SHALL be synthesised.

Verification (N_LED=4, STEP_CNT=8, DEB_CNT=4, LED_KEY_DEBOUNCE_EN defined unless noted)
REQ-029 Reset release, keys idle 100 cycles -> led=0000, mode=00, paused=0 throughout.
REQ-030 key[1] held low 20 cycles -> mode=10; led 0001, 0010, 0100, 1000, 0001 changing every 8 cycles.
REQ-031 key[0] low with 1-cycle glitches every 3 cycles for 30 cycles, then stable -> no mode change during glitching; MIRROR 1001/0110 only after 4 stable cycles; without macro, each glitch edge produces a press.
REQ-032 In BLINK, key[3] press at step 1 -> led holds 0000 and paused=1 for 50 cycles; second key[3] press -> resumes, next change after remaining timer cycles.
REQ-033 key[0] and key[2] pressed same cycle from OFF -> mode=01 only; then key[0] again -> mode=00, led=0000.
REQ-034 In RUN step 2, sys_rst_n pulsed low for 1 cycle with key[1] held -> led=0000, mode=00 immediately; no RUN re-entry until key[1] released and re-pressed.
